// File: rtl/riscx_pkg.sv
// rtl/riscx_pkg.sv - shared register-file widths, constants and skid-buffer state type
package riscx_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } skid_state_t;

    // True when operand a names a real register and equals b; x0 never hazards.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard for outstanding loads with 3-operand lookup
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   set_en, set_rd        mark a register busy (load issued)
//   clr_en, clr_rd        mark a register free (load data accepted)
//   rs1, rs2, rd          decode operands to look up
//   hit                   some nonzero operand is busy
//   set_was_busy,
//   clr_was_busy          current busy state of set_rd / clr_rd
//                         (only with REGFILE_WB_SBCHECK_EN)
module regfile_scoreboard
    import riscx_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
`ifdef REGFILE_WB_SBCHECK_EN
    output logic                  set_was_busy,
    output logic                  clr_was_busy,
`endif
    output logic                  hit
);

    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_next;

    // Clear is applied before set so a re-issue on the same edge keeps the bit.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != REG_ZERO)) begin
            busy_next[set_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // busy[0] is always zero, so x0 operands drop out naturally.
    assign hit = busy[rs1] | busy[rs2] | busy[rd];

`ifdef REGFILE_WB_SBCHECK_EN
    assign set_was_busy = busy[set_rd];
    assign clr_was_busy = busy[clr_rd];
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-port arbiter (execute vs load) with skid buffer and hazard stall
//
// Optional feature macro: REGFILE_WB_SBCHECK_EN (adds sticky sbError output).
//
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   exValid/exReady/exRd/exData     execute result handshake
//   ldValid/ldReady/ldRd/ldData     load data handshake
//   issueLoad, issueRd              load issue; marks issueRd busy
//   rs1, rs2, rd                    decode operands checked for hazards
//   stall                           combinational decode hold
//   writeRegister, wbRd, wbData     registered register-file write port
//   sbError                         sticky scoreboard consistency error (macro only)
module regfile_wb_arbiter
    import riscx_pkg::*;
#(
    parameter int XLEN         = riscx_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  exValid,
    output logic                  exReady,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic [XLEN-1:0]       exData,
    input  logic                  ldValid,
    output logic                  ldReady,
    input  logic [REG_ADDR_W-1:0] ldRd,
    input  logic [XLEN-1:0]       ldData,
    input  logic                  issueLoad,
    input  logic [REG_ADDR_W-1:0] issueRd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  stall,
`ifdef REGFILE_WB_SBCHECK_EN
    output logic                  sbError,
`endif
    output logic                  writeRegister,
    output logic [REG_ADDR_W-1:0] wbRd,
    output logic [XLEN-1:0]       wbData
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    skid_state_t           state, state_next;
    logic [3:0]            starve_cnt, starve_cnt_next;
    logic [REG_ADDR_W-1:0] skid_rd;
    logic [XLEN-1:0]       skid_data;
    logic                  skid_load;

    logic                  sel_valid;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  ld_accept;
    logic                  sb_hit;
    logic                  skid_hit;
    logic                  wb_hit;

    // Arbitration: loads win by default (their source cannot be held cheaply);
    // a losing execute result parks in the skid buffer and is forced through
    // once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        exReady         = 1'b0;
        ldReady         = 1'b1;
        skid_load       = 1'b0;
        sel_valid       = 1'b0;
        sel_rd          = REG_ZERO;
        sel_data        = '0;
        case (state)
            EMPTY: begin
                exReady = 1'b1;
                if (ldValid) begin
                    sel_valid = 1'b1;
                    sel_rd    = ldRd;
                    sel_data  = ldData;
                    if (exValid) begin
                        skid_load       = 1'b1;
                        state_next      = HELD;
                        starve_cnt_next = 4'd0;
                    end
                end else if (exValid) begin
                    sel_valid = 1'b1;
                    sel_rd    = exRd;
                    sel_data  = exData;
                end
            end
            HELD: begin
                if (!ldValid || (starve_cnt == STARVE_MAX)) begin
                    ldReady         = 1'b0;
                    sel_valid       = 1'b1;
                    sel_rd          = skid_rd;
                    sel_data        = skid_data;
                    state_next      = EMPTY;
                    starve_cnt_next = 4'd0;
                end else begin
                    sel_valid       = 1'b1;
                    sel_rd          = ldRd;
                    sel_data        = ldData;
                    starve_cnt_next = starve_cnt + 4'd1;
                end
            end
            default: begin
                state_next      = EMPTY;
                starve_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            starve_cnt <= 4'd0;
            skid_rd    <= REG_ZERO;
            skid_data  <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            if (skid_load) begin
                skid_rd   <= exRd;
                skid_data <= exData;
            end
        end
    end

    // x0 writes complete the handshake but never pulse the write enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            writeRegister <= 1'b0;
            wbRd          <= REG_ZERO;
            wbData        <= '0;
        end else begin
            writeRegister <= sel_valid && (sel_rd != REG_ZERO);
            if (sel_valid) begin
                wbRd   <= sel_rd;
                wbData <= sel_data;
            end
        end
    end

    assign ld_accept = ldValid && ldReady;

`ifdef REGFILE_WB_SBCHECK_EN
    logic set_was_busy;
    logic clr_was_busy;
`endif

    regfile_scoreboard u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .set_en       (issueLoad),
        .set_rd       (issueRd),
        .clr_en       (ld_accept),
        .clr_rd       (ldRd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
`ifdef REGFILE_WB_SBCHECK_EN
        .set_was_busy (set_was_busy),
        .clr_was_busy (clr_was_busy),
`endif
        .hit          (sb_hit)
    );

    // A parked execute result and the in-flight write are not yet visible in
    // the register file, so both count as hazards alongside busy loads.
    assign skid_hit = (state == HELD) &&
                      (reg_hit(rs1, skid_rd) || reg_hit(rs2, skid_rd) || reg_hit(rd, skid_rd));
    assign wb_hit   = writeRegister &&
                      (reg_hit(rs1, wbRd) || reg_hit(rs2, wbRd) || reg_hit(rd, wbRd));
    assign stall    = sb_hit || skid_hit || wb_hit;

`ifdef REGFILE_WB_SBCHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbError <= 1'b0;
        end else if ((ld_accept && (ldRd != REG_ZERO) && !clr_was_busy) ||
                     (issueLoad && (issueRd != REG_ZERO) && set_was_busy)) begin
            sbError <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed table-driven bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        exValid = 1'b0;
    logic        exReady;
    logic [4:0]  exRd = '0;
    logic [31:0] exData = '0;
    logic        ldValid = 1'b0;
    logic        ldReady;
    logic [4:0]  ldRd = '0;
    logic [31:0] ldData = '0;
    logic        issueLoad = 1'b0;
    logic [4:0]  issueRd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd = '0;
    logic        stall;
    logic        writeRegister;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
`ifdef REGFILE_WB_SBCHECK_EN
    logic        sbError;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .exValid       (exValid),
        .exReady       (exReady),
        .exRd          (exRd),
        .exData        (exData),
        .ldValid       (ldValid),
        .ldReady       (ldReady),
        .ldRd          (ldRd),
        .ldData        (ldData),
        .issueLoad     (issueLoad),
        .issueRd       (issueRd),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .stall         (stall),
`ifdef REGFILE_WB_SBCHECK_EN
        .sbError       (sbError),
`endif
        .writeRegister (writeRegister),
        .wbRd          (wbRd),
        .wbData        (wbData)
    );

    typedef struct {
        logic        exv;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        ldv;
        logic [4:0]  ldrd;
        logic [31:0] ldd;
        logic        iss;
        logic [4:0]  issrd;
        logic [4:0]  r1, r2, r3;
        logic        e_exr, e_ldr, e_st, e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                       input logic ldv, input logic [4:0] ldrd, input logic [31:0] ldd,
                       input logic iss, input logic [4:0] issrd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                       input logic e_exr, input logic e_ldr, input logic e_st, input logic e_wr,
                       input logic [4:0] e_rd, input logic [31:0] e_data);
        vec_t v;
        v.exv = exv; v.exrd = exrd; v.exd = exd;
        v.ldv = ldv; v.ldrd = ldrd; v.ldd = ldd;
        v.iss = iss; v.issrd = issrd;
        v.r1 = r1; v.r2 = r2; v.r3 = r3;
        v.e_exr = e_exr; v.e_ldr = e_ldr; v.e_st = e_st; v.e_wr = e_wr;
        v.e_rd = e_rd; v.e_data = e_data;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        exValid = 0; exRd = 0; exData = 0;
        ldValid = 0; ldRd = 0; ldData = 0;
        issueLoad = 0; issueRd = 0;
        rs1 = 0; rs2 = 0; rd = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
    endtask

    initial begin
        //   exv rd  data          ldv rd  data          iss rd  rs1 rs2 rd   exR ldR st wr  wbRd wbData
        add(1, 5,  32'hDEADBEEF, 0, 0,  0,            0, 0,  0,  0,  0,   1,  1,  0, 1,  5,  32'hDEADBEEF);
        add(0, 0,  0,            0, 0,  0,            0, 0,  0,  0,  0,   1,  1,  0, 0,  0,  0);
        // simultaneous ex/ld: load first, execute drains next cycle
        add(1, 3,  32'h11,       1, 4,  32'h22,       0, 0,  0,  0,  0,   1,  1,  0, 1,  4,  32'h22);
        add(0, 0,  0,            0, 0,  0,            0, 0,  3,  0,  0,   0,  0,  1, 1,  3,  32'h11);
        add(0, 0,  0,            0, 0,  0,            0, 0,  3,  0,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  3,  0,  0,   1,  1,  0, 0,  0,  0);
        // starvation: five HELD cycles, drain forced on the fifth
        add(1, 10, 32'hA,        1, 11, 32'hB1,       0, 0,  0,  0,  0,   1,  1,  0, 1,  11, 32'hB1);
        add(0, 0,  0,            1, 12, 32'hB2,       0, 0,  0,  0,  0,   0,  1,  0, 1,  12, 32'hB2);
        add(0, 0,  0,            1, 13, 32'hB3,       0, 0,  0,  0,  0,   0,  1,  0, 1,  13, 32'hB3);
        add(0, 0,  0,            1, 14, 32'hB4,       0, 0,  0,  0,  0,   0,  1,  0, 1,  14, 32'hB4);
        add(0, 0,  0,            1, 15, 32'hB5,       0, 0,  0,  0,  0,   0,  1,  0, 1,  15, 32'hB5);
        add(0, 0,  0,            1, 16, 32'hB6,       0, 0,  0,  0,  0,   0,  0,  0, 1,  10, 32'hA);
        add(0, 0,  0,            1, 16, 32'hB6,       0, 0,  0,  0,  0,   1,  1,  0, 1,  16, 32'hB6);
        // x0 traffic
        add(1, 0,  32'h55,       0, 0,  0,            0, 0,  0,  0,  0,   1,  1,  0, 0,  0,  0);
        add(0, 0,  0,            1, 0,  32'h66,       1, 0,  0,  0,  0,   1,  1,  0, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  0,  0,  0,   1,  1,  0, 0,  0,  0);
        // scoreboard RAW on x7
        add(0, 0,  0,            0, 0,  0,            1, 7,  0,  0,  0,   1,  1,  0, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  0,  7,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            1, 7,  32'h77,       0, 0,  0,  0,  7,   1,  1,  1, 1,  7,  32'h77);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  0, 0,  0,  0);
        // re-issue on the clearing edge keeps x7 busy
        add(0, 0,  0,            0, 0,  0,            1, 7,  0,  0,  0,   1,  1,  0, 0,  0,  0);
        add(0, 0,  0,            1, 7,  32'h78,       1, 7,  7,  0,  0,   1,  1,  1, 1,  7,  32'h78);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            1, 7,  32'h79,       0, 0,  0,  0,  0,   1,  1,  0, 1,  7,  32'h79);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  1, 0,  0,  0);
        add(0, 0,  0,            0, 0,  0,            0, 0,  7,  0,  0,   1,  1,  0, 0,  0,  0);

        do_reset();
        #1;
        chk("rst_exReady", 0, 32'(exReady), 32'd1);
        chk("rst_ldReady", 0, 32'(ldReady), 32'd1);
        chk("rst_stall",   0, 32'(stall),   32'd0);
        chk("rst_wr",      0, 32'(writeRegister), 32'd0);
        chk("rst_wbRd",    0, 32'(wbRd),    32'd0);
        chk("rst_wbData",  0, wbData,       32'd0);
`ifdef REGFILE_WB_SBCHECK_EN
        chk("rst_sbError", 0, 32'(sbError), 32'd0);
`endif
        @(posedge clock);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            exValid = vq[i].exv; exRd = vq[i].exrd; exData = vq[i].exd;
            ldValid = vq[i].ldv; ldRd = vq[i].ldrd; ldData = vq[i].ldd;
            issueLoad = vq[i].iss; issueRd = vq[i].issrd;
            rs1 = vq[i].r1; rs2 = vq[i].r2; rd = vq[i].r3;
            #1;
            chk("exReady", i, 32'(exReady), 32'(vq[i].e_exr));
            chk("ldReady", i, 32'(ldReady), 32'(vq[i].e_ldr));
            chk("stall",   i, 32'(stall),   32'(vq[i].e_st));
            @(posedge clock);
            #1;
            chk("writeRegister", i, 32'(writeRegister), 32'(vq[i].e_wr));
            if (vq[i].e_wr) begin
                chk("wbRd",   i, 32'(wbRd), 32'(vq[i].e_rd));
                chk("wbData", i, wbData,    vq[i].e_data);
            end
        end

        // reset mid-operation: busy x8 and a parked execute result are discarded
        idle_inputs();
        issueLoad = 1; issueRd = 8;
        @(posedge clock); #1;
        idle_inputs();
        exValid = 1; exRd = 20; exData = 32'h2020;
        ldValid = 1; ldRd = 21; ldData = 32'h2121;
        @(posedge clock); #1;
        idle_inputs();
        rs1 = 8;
        #1;
        chk("mid_stall_before", 0, 32'(stall),   32'd1);
        chk("mid_exReady_held", 0, 32'(exReady), 32'd0);
        reset_n = 0;
        #1;
        chk("mid_rst_stall",   0, 32'(stall),   32'd0);
        chk("mid_rst_exReady", 0, 32'(exReady), 32'd1);
        chk("mid_rst_ldReady", 0, 32'(ldReady), 32'd1);
        chk("mid_rst_wr",      0, 32'(writeRegister), 32'd0);
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;
        chk("mid_post_wr",    0, 32'(writeRegister), 32'd0);
        chk("mid_post_stall", 0, 32'(stall),         32'd0);

`ifdef REGFILE_WB_SBCHECK_EN
        // load to a non-busy register flags an error that holds until reset
        idle_inputs();
        ldValid = 1; ldRd = 9; ldData = 32'h99;
        #1;
        chk("sb_pre", 0, 32'(sbError), 32'd0);
        @(posedge clock); #1;
        idle_inputs();
        chk("sb_set", 0, 32'(sbError), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chk("sb_hold", 0, 32'(sbError), 32'd1);
        reset_n = 0;
        #1;
        chk("sb_rst", 0, 32'(sbError), 32'd0);
        @(posedge clock); #1;
        reset_n = 1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
